// File: rtl/rca_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit ripple-carry slice.
package rca_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/S_RCA.sv
// 4-bit ripple-carry adder slice; purely combinational.
module S_RCA
    import rca_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands through one S_RCA a nibble per clock, LSB first,
// carrying between cycles through a register.
module nibble_serial_adder
    import rca_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a_in,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b_in,
    input  logic                          cin_in,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   sum,
    output logic                          cout
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned CNT_W = $clog2(NIBBLES + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_busy;
    logic               r_done;
    logic               w_busy_next;
    logic               w_done_next;
    logic               w_load;
    logic               w_step;
    logic               w_finish;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_count;

    logic [NIBBLE_W-1:0] w_s;
    logic                w_cout;
    logic [W-1:0]        w_acc_next;
    logic                w_last;

    S_RCA u_rca (
        .a    (r_a[NIBBLE_W-1:0]),
        .b    (r_b[NIBBLE_W-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // New nibble enters at the top; after NIBBLES shifts the accumulator holds the full sum.
    assign w_acc_next = (r_acc >> NIBBLE_W) | (W'(w_s) << (W - NIBBLE_W));
    assign w_last     = (r_count == CNT_W'(NIBBLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = ST_ADD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ADD: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_busy_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand shift registers, carry chain, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_count <= '0;
        end else if (w_load) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin_in;
            r_count <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> NIBBLE_W;
            r_b     <= r_b >> NIBBLE_W;
            r_acc   <= w_acc_next;
            r_carry <= w_cout;
            r_count <= r_count + CNT_W'(1);
            if (w_finish) begin
                r_sum  <= w_acc_next;
                r_cout <= w_cout;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) against a plain-arithmetic model.
module tb_nibble_serial_adder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int vectors = 0;
    int miscompares = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .cin_in (cin_in),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one addition and returns in the cycle where done should be high.
    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci);
        logic [W:0] expect_full;
        int n;
        expect_full = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = ci;
        tick();
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            if (done !== 1'b0) chk({tag, "_done_while_busy"}, 32'(done), 32'd0);
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(N));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(expect_full[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(expect_full[W]));
    endtask

    task automatic idle_check(input string tag, input logic [W-1:0] exp_sum, input logic exp_cout);
        tick();
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_cout_hold"}, 32'(cout), 32'(exp_cout));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rf;
        int           seen_done;

        // Reset asserted between clock edges: outputs must clear without a clock.
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        #1 rst = 1'b0;
        tick();

        do_add("basic", 16'h1234, 16'h4321, 1'b0);
        idle_check("basic", 16'h5555, 1'b0);

        do_add("ripple", 16'hFFFF, 16'h0001, 1'b0);
        idle_check("ripple", 16'h0000, 1'b1);

        do_add("max", 16'hFFFF, 16'hFFFF, 1'b1);
        idle_check("max", 16'hFFFF, 1'b1);

        // Second start two cycles into an operation must be dropped, not queued.
        start = 1'b1; a_in = 16'h0001; b_in = 16'h0001; cin_in = 1'b0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a_in = 16'hAAAA; b_in = 16'h5555; cin_in = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ignored_done", 32'(done), 32'd1);
        chk("ignored_sum",  32'(sum),  32'h0002);
        chk("ignored_cout", 32'(cout), 32'd0);
        idle_check("ignored", 16'h0002, 1'b0);

        // Back-to-back: second start issued in the DONE cycle of the first.
        do_add("b2b_first", 16'h0003, 16'h0004, 1'b0);
        do_add("b2b_second", 16'h00FF, 16'h0001, 1'b0);
        idle_check("b2b", 16'h0100, 1'b0);

        // Abort in the second ADD cycle.
        start = 1'b1; a_in = 16'h8000; b_in = 16'h8000; cin_in = 1'b0;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum",  32'(sum),  32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        #1 rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_sum_stays", 32'(sum), 32'd0);

        do_add("after_abort", 16'h8000, 16'h8000, 1'b0);
        idle_check("after_abort", 16'h0000, 1'b1);

        // Randomized operands, alternating idle gaps and back-to-back starts.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rf = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            do_add($sformatf("rand%0d", i), ra, rb, rc);
            if (i % 3 == 0) idle_check($sformatf("rand%0d", i), rf[W-1:0], rf[W]);
        end
        idle_check("final", rf[W-1:0], rf[W]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
